jtag_sequencer: RTL

JTAG_SEQUENCER -- requirements
Module: jtag_sequencer

---
 rtl/jtag_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/jtag_sequencer.sv
// Command-driven JTAG sequencer: turns RESET / SHIFT_IR / SHIFT_DR / IDLE commands
// into registered TMS/TDI sequences and returns captured TDO bits as a response.
module jtag_sequencer #(
   parameter int RESET_CYCLES = 5
) (
   input  logic        clk_tck,
   input  logic        trst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [4:0]  cmd_len,
   input  logic [31:0] cmd_data,
   output logic        tms,
   output logic        tdi,
   output logic        tap_enable,
   input  logic        tdo,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        busy
);

   // Handshakes: a command transfers on a posedge with cmd_valid & cmd_ready, a response
   // on a posedge with rsp_valid & rsp_ready; valid holds its payload stable until then.

   localparam logic [1:0] OP_RESET    = 2'b00;
   localparam logic [1:0] OP_SHIFT_IR = 2'b01;
   localparam logic [1:0] OP_SHIFT_DR = 2'b10;
   localparam logic [1:0] OP_IDLE     = 2'b11;
   localparam logic [4:0] RST_LAST    = 5'(RESET_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE, S_RST, S_PRE, S_SHIFT, S_POST, S_RUN, S_RSP
   } state_t;

   state_t      state, state_d;
   logic [4:0]  cnt, cnt_d;
   logic [1:0]  op_q, op_d;
   logic [4:0]  len_q, len_d;
   logic [31:0] data_q, data_d;
   logic        synced, synced_d;
   logic [31:0] rsp_d;
   logic        tms_d, tdi_d;
   logic        accept;

   assign accept = cmd_valid & cmd_ready;

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      op_d     = op_q;
      len_d    = len_q;
      data_d   = data_q;
      synced_d = synced;
      rsp_d    = rsp_data;
      tms_d    = 1'b0;
      tdi_d    = 1'b0;

      case (state)
         S_IDLE: begin
            if (accept) begin
               op_d   = cmd_op;
               len_d  = cmd_len;
               data_d = cmd_data;
               rsp_d  = '0;
               cnt_d  = '0;
               if (cmd_op == OP_RESET || !synced) state_d = S_RST;
               else if (cmd_op == OP_IDLE)        state_d = S_RUN;
               else                               state_d = S_PRE;
            end
         end
         S_RST: begin
            if (cnt == RST_LAST) begin
               synced_d = 1'b1;
               cnt_d    = '0;
               if (op_q == OP_RESET)     state_d = S_RSP;
               else if (op_q == OP_IDLE) state_d = S_RUN;
               else                      state_d = S_PRE;
            end else begin
               cnt_d = cnt + 5'd1;
            end
         end
         S_PRE: begin
            if (cnt == ((op_q == OP_SHIFT_IR) ? 5'd3 : 5'd2)) begin
               cnt_d   = '0;
               state_d = S_SHIFT;
            end else begin
               cnt_d = cnt + 5'd1;
            end
         end
         S_SHIFT: begin
            rsp_d[cnt] = tdo;
            if (cnt == len_q) begin
               cnt_d   = '0;
               state_d = S_POST;
            end else begin
               cnt_d = cnt + 5'd1;
            end
         end
         S_POST: begin
            if (cnt == 5'd1) state_d = S_RSP;
            else             cnt_d   = cnt + 5'd1;
         end
         S_RUN: begin
            if (cnt == len_q) state_d = S_RSP;
            else              cnt_d   = cnt + 5'd1;
         end
         S_RSP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Pin values belong to the cycle being entered, so they register alongside the state.
      case (state_d)
         S_RST:   tms_d = (cnt_d < RST_LAST);
         S_PRE:   tms_d = (cnt_d == 5'd0) || (op_d == OP_SHIFT_IR && cnt_d == 5'd1);
         S_SHIFT: begin
            tms_d = (cnt_d == len_d);
            tdi_d = data_d[cnt_d];
         end
         S_POST:  tms_d = (cnt_d == 5'd0);
         default: tms_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk_tck or negedge trst_n) begin
      if (!trst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         op_q       <= OP_RESET;
         len_q      <= '0;
         data_q     <= '0;
         synced     <= 1'b0;
         tms        <= 1'b0;
         tdi        <= 1'b0;
         tap_enable <= 1'b0;
         cmd_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         busy       <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         op_q       <= op_d;
         len_q      <= len_d;
         data_q     <= data_d;
         synced     <= synced_d;
         tms        <= tms_d;
         tdi        <= tdi_d;
         tap_enable <= 1'b1;
         cmd_ready  <= (state_d == S_IDLE);
         rsp_valid  <= (state_d == S_RSP);
         rsp_data   <= rsp_d;
         busy       <= (state_d != S_IDLE);
      end
   end

endmodule
